cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Synthesizable run controller for cpu5_pipeline.
- Streams a program image into instruction memory over a valid/ready port.
- Holds the core in reset for a programmable number of cycles, then releases it.
- Counts cycles and retired instructions, and stops the run on a halt instruction or a cycle budget.
- Replaces the fixed "readmemh + reset pulse + fixed delay" bring-up with a parametrised, reusable block for benches and FPGA bring-up.

Parameters:
XLEN, 32, instruction/data word width
IMEM_DEPTH, 256, instruction memory depth in words (power of 2)
AW, $clog2(IMEM_DEPTH), imem address width (derived)
RESET_CYCLES, 2, cycles cpu_reset is held after load completes (>=1)
MAX_CYCLES, 50, run budget in core cycles before timeout (>=1)
CNT_W, 32, counter width
HALT_INSTR, 32'h0000_006F, retiring this encoding halts the run

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a load+run sequence
abort  in  1  forces return to IDLE from any state
ld_valid  in  1  program word valid
ld_data  in  XLEN  program word
ld_last  in  1  marks final program word
ld_ready  out  1  controller accepts a program word
imem_we  out  1  instruction memory write strobe
imem_waddr  out  AW  instruction memory write address
imem_wdata  out  XLEN  instruction memory write data
cpu_reset  out  1  reset to core, active-high
cpu_run  out  1  clock enable to core
retire_valid  in  1  core retired an instruction this cycle
retire_instr  in  XLEN  encoding of retired instruction
busy  out  1  state is LOAD, HOLD or RUN
done  out  1  run finished, sticky until next start/abort
halted  out  1  done via HALT_INSTR
timeout  out  1  done via cycle budget
load_err  out  1  image exceeded IMEM_DEPTH
cycle_count  out  CNT_W  core cycles elapsed in RUN
retired_count  out  CNT_W  instructions retired in RUN

Behaviour:
- Reset (async):
  - State IDLE.
  - cpu_reset=1; all other outputs 0, including counters and imem_* outputs.
- States: IDLE, LOAD, HOLD, RUN, DONE.
- IDLE:
  - cpu_reset=1, cpu_run=0, ld_ready=0.
  - start -> LOAD; write pointer=0; counters and flags cleared.
- LOAD:
  - ld_ready=1, cpu_reset=1.
  - Handshake = ld_valid & ld_ready.
  - Each handshake at edge k: imem_we=1, imem_waddr=ptr, imem_wdata=ld_data, all registered, visible in cycle k+1. ptr then increments.
  - Handshake with ld_last -> HOLD; hold counter=0.
  - Handshake at ptr==IMEM_DEPTH-1 without ld_last: word is written, load_err=1, done=1, state -> DONE; core never released.
  - ld_last at ptr==IMEM_DEPTH-1 is legal.
- HOLD:
  - cpu_reset=1, cpu_run=0.
  - Stays exactly RESET_CYCLES cycles, then -> RUN.
- RUN:
  - cpu_reset=0, cpu_run=1.
  - cycle_count +1 per cycle. retired_count +1 per cycle with retire_valid=1.
  - Both counters saturate at 2^CNT_W-1.
  - retire_valid & retire_instr==HALT_INSTR -> DONE, halted=1. The halt instruction is counted.
  - cycle_count reaching MAX_CYCLES (count value after increment) -> DONE, timeout=1.
  - Halt and budget in the same cycle: halted=1, timeout=0.
- DONE:
  - cpu_run=0, cpu_reset=0, so core state stays observable.
  - Counters frozen; done=1.
  - start -> LOAD, clearing counters and flags.
- start while busy is ignored.
- abort, from any state except IDLE: next cycle IDLE, cpu_reset=1. Counters and flags clear; any in-flight imem_we drops. abort has priority over start.
- busy is combinational from state; all other outputs are registered.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum localparams (ST_IDLE..ST_DONE);
  - HALT_INSTR default (jal x0,0);
  - XLEN default.
- One natural sub-module: sat_counter (parametrised width, enable, synchronous clear, saturate). It is instanced twice, for cycle_count and retired_count.

Test Plan:
- Load 4 words (ld_last on the 4th), RESET_CYCLES=2, no halt, MAX_CYCLES=50:
  - imem_waddr 0..3 written;
  - cpu_reset deasserts 2 cycles after the last write;
  - done=1, timeout=1, cycle_count=50.
- Halt: retire_instr=32'h0000_006F with retire_valid in RUN cycle 10 -> halted=1, timeout=0, cycle_count=10, retired_count includes the halt.
- Simultaneous: halt retires in cycle 50 with MAX_CYCLES=50 -> halted=1, timeout=0.
- Overflow: IMEM_DEPTH=4, stream 5 words -> load_err=1 after the 4th handshake, address 3 written, cpu_reset stays 1, done=1.
- Backpressure and abort:
  - ld_valid toggling every other cycle -> words land at consecutive addresses with no gaps or duplicates.
  - abort mid-RUN -> IDLE next cycle, cpu_reset=1, counters 0.
- Async reset asserted mid-LOAD between clock edges -> outputs clear immediately; a subsequent start reloads from address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu5_pipeline run controller: controller states,
// default word width and the encoding that ends a run (jal x0,0).
package cpu_pkg;

  localparam int CPU_XLEN = 32;
  localparam logic [31:0] CPU_HALT_INSTR = 32'h0000_006F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping. It has an enable and a
// synchronous clear, and the clear wins over the enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for cpu5_pipeline: streams the program image into imem, holds the
// core in reset, then runs it until a halt instruction retires or the cycle budget runs out.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int              XLEN         = CPU_XLEN,
  parameter int              IMEM_DEPTH   = 256,
  parameter int              AW           = $clog2(IMEM_DEPTH),
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 50,
  parameter int              CNT_W        = 32,
  parameter logic [XLEN-1:0] HALT_INSTR   = XLEN'(CPU_HALT_INSTR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             ld_valid,
  input  logic [XLEN-1:0]  ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             imem_we,
  output logic [AW-1:0]    imem_waddr,
  output logic [XLEN-1:0]  imem_wdata,
  output logic             cpu_reset,
  output logic             cpu_run,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_instr,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic             load_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t            state, state_nx;
  logic [AW-1:0]     wptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hs, last_slot, halt_hit, budget_hit, start_ok, cnt_clr;

  assign hs         = (state == ST_LOAD) && ld_valid && ld_ready;
  assign last_slot  = (wptr == AW'(IMEM_DEPTH - 1));
  assign halt_hit   = (state == ST_RUN) && retire_valid && (retire_instr == HALT_INSTR);
  assign budget_hit = (state == ST_RUN) && (cycle_count >= CNT_W'(MAX_CYCLES - 1));
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign cnt_clr    = abort || start_ok;
  assign busy       = (state == ST_LOAD) || (state == ST_HOLD) || (state == ST_RUN);

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state_nx = ST_LOAD;
        ST_LOAD: begin
          if (hs && ld_last)        state_nx = ST_HOLD;
          else if (hs && last_slot) state_nx = ST_DONE;
        end
        ST_HOLD: if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_nx = ST_RUN;
        ST_RUN:  if (halt_hit || budget_hit) state_nx = ST_DONE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state. In DONE, cpu_reset keeps whatever
  // value it had, so an overflowed load never releases the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wptr       <= '0;
      hold_cnt   <= '0;
      ld_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      cpu_run    <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      ld_ready  <= (state_nx == ST_LOAD);
      cpu_run   <= (state_nx == ST_RUN);
      cpu_reset <= (state_nx == ST_DONE) ? cpu_reset : (state_nx != ST_RUN);
      hold_cnt  <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
      imem_we   <= hs && !abort;
      if (hs) begin
        imem_waddr <= wptr;
        imem_wdata <= ld_data;
      end
      if (cnt_clr) begin
        wptr <= '0;
      end else if (hs) begin
        wptr <= wptr + 1'b1;
      end
      if (cnt_clr) begin
        done     <= 1'b0;
        halted   <= 1'b0;
        timeout  <= 1'b0;
        load_err <= 1'b0;
      end else begin
        if (hs && !ld_last && last_slot) begin
          load_err <= 1'b1;
          done     <= 1'b1;
        end
        if ((state == ST_RUN) && (state_nx == ST_DONE)) begin
          done    <= 1'b1;
          halted  <= halt_hit;
          timeout <= !halt_hit;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    ((state == ST_RUN) && !abort),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    ((state == ST_RUN) && retire_valid && !abort),
    .count (retired_count)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a default-sized instance for load/run/halt/abort,
// and a 4-word imem instance for the load overflow case.
module tb_cpu_run_ctrl;

  logic        clk, reset;
  logic        start, abort, ld_valid, ld_last, retire_valid;
  logic [31:0] ld_data, retire_instr;
  logic        ld_ready, imem_we, cpu_reset, cpu_run, busy, done, halted, timeout, load_err;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata, cycle_count, retired_count;

  logic        start4, ld_valid4, ld_last4;
  logic [31:0] ld_data4;
  logic        ld_ready4, imem_we4, cpu_reset4, cpu_run4, busy4, done4, halted4, timeout4, load_err4;
  logic [1:0]  imem_waddr4;
  logic [31:0] imem_wdata4, cycle_count4, retired_count4;

  int total = 0;
  int bad = 0;

  cpu_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_run(cpu_run),
    .retire_valid(retire_valid), .retire_instr(retire_instr),
    .busy(busy), .done(done), .halted(halted), .timeout(timeout), .load_err(load_err),
    .cycle_count(cycle_count), .retired_count(retired_count)
  );

  cpu_run_ctrl #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(1'b0),
    .ld_valid(ld_valid4), .ld_data(ld_data4), .ld_last(ld_last4), .ld_ready(ld_ready4),
    .imem_we(imem_we4), .imem_waddr(imem_waddr4), .imem_wdata(imem_wdata4),
    .cpu_reset(cpu_reset4), .cpu_run(cpu_run4),
    .retire_valid(1'b0), .retire_instr(32'h0),
    .busy(busy4), .done(done4), .halted(halted4), .timeout(timeout4), .load_err(load_err4),
    .cycle_count(cycle_count4), .retired_count(retired_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic v, input logic [31:0] d,
                               input logic l, input logic rv, input logic [31:0] ri);
    start        = st;
    abort        = ab;
    ld_valid     = v;
    ld_data      = d;
    ld_last      = l;
    retire_valid = rv;
    retire_instr = ri;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    start4 = 0; ld_valid4 = 0; ld_data4 = 0; ld_last4 = 0;
    #12;
    checkOutput("rst_cpu_reset", cpu_reset, 1);
    checkOutput("rst_ld_ready", ld_ready, 0);
    checkOutput("rst_imem_we", imem_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cycle_count", cycle_count, 0);
    reset = 1'b0;
    tick();

    // Load 4 words, hold 2 cycles, run to the 50-cycle budget with non-halt retires.
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    checkOutput("t1_ld_ready", ld_ready, 1);
    checkOutput("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 32'hA000 + i, (i == 3), 0, 32'h0);
      tick();
      checkOutput("t1_we", imem_we, 1);
      checkOutput("t1_waddr", imem_waddr, i);
      checkOutput("t1_wdata", imem_wdata, 32'hA000 + i);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 32'h13);
    checkOutput("t1_hold_ready", ld_ready, 0);
    tick();
    checkOutput("t1_hold_cpu_reset", cpu_reset, 1);
    checkOutput("t1_hold_we", imem_we, 0);
    tick();
    checkOutput("t1_run_cpu_reset", cpu_reset, 0);
    checkOutput("t1_run_cpu_run", cpu_run, 1);
    for (int c = 0; c < 49; c++) tick();
    checkOutput("t1_cc49", cycle_count, 49);
    checkOutput("t1_done_early", done, 0);
    tick();
    checkOutput("t1_done", done, 1);
    checkOutput("t1_timeout", timeout, 1);
    checkOutput("t1_halted", halted, 0);
    checkOutput("t1_cc50", cycle_count, 50);
    checkOutput("t1_rc50", retired_count, 50);
    checkOutput("t1_done_cpu_run", cpu_run, 0);
    checkOutput("t1_done_cpu_reset", cpu_reset, 0);
    checkOutput("t1_done_busy", busy, 0);
    tick();
    tick();
    checkOutput("t1_frozen_cc", cycle_count, 50);
    checkOutput("t1_frozen_rc", retired_count, 50);

    // Halt retires in RUN cycle 10 after 5 ordinary retires.
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    checkOutput("t2_clear_cc", cycle_count, 0);
    checkOutput("t2_clear_done", done, 0);
    applyStimulus(0, 0, 1, 32'hB000, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    tick();
    checkOutput("t2_run", cpu_run, 1);
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(0, 0, 0, 32'h0, 0, (c % 2 == 1), 32'h13);
      tick();
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 32'h0000_006F);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t2_halted", halted, 1);
    checkOutput("t2_timeout", timeout, 0);
    checkOutput("t2_cc", cycle_count, 10);
    checkOutput("t2_rc", retired_count, 6);
    checkOutput("t2_done", done, 1);

    // Halt and budget land on the same cycle: halt wins.
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 32'hC000, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    tick();
    for (int c = 0; c < 49; c++) tick();
    checkOutput("t3_done_early", done, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 32'h0000_006F);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t3_halted", halted, 1);
    checkOutput("t3_timeout", timeout, 0);
    checkOutput("t3_cc", cycle_count, 50);
    checkOutput("t3_rc", retired_count, 1);

    // Backpressure: valid every other cycle, then a start pulse and an abort in RUN.
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, (i % 2 == 0), 32'h100 + i, (i == 6), 0, 32'h0);
      tick();
      checkOutput("t4_we", imem_we, (i % 2 == 0));
      if (i % 2 == 0) begin
        checkOutput("t4_waddr", imem_waddr, i / 2);
        checkOutput("t4_wdata", imem_wdata, 32'h100 + i);
      end
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    tick();
    for (int c = 1; c <= 5; c++) begin
      applyStimulus((c == 3), 0, 0, 32'h0, 0, 1, 32'h13);
      tick();
    end
    checkOutput("t4_busy_start_ignored", busy, 1);
    checkOutput("t4_cc", cycle_count, 5);
    checkOutput("t4_rc", retired_count, 5);
    applyStimulus(1, 1, 0, 32'h0, 0, 1, 32'h13);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t4_abort_busy", busy, 0);
    checkOutput("t4_abort_cpu_reset", cpu_reset, 1);
    checkOutput("t4_abort_cpu_run", cpu_run, 0);
    checkOutput("t4_abort_ld_ready", ld_ready, 0);
    checkOutput("t4_abort_cc", cycle_count, 0);
    checkOutput("t4_abort_rc", retired_count, 0);
    tick();
    checkOutput("t4_idle_stays", busy, 0);

    // Async reset between edges during LOAD, then reload from address 0.
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1, 32'hD000 + i, 0, 0, 32'h0);
      tick();
    end
    checkOutput("t5_pre_waddr", imem_waddr, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    #3 reset = 1'b1;
    #1;
    checkOutput("t5_ar_ld_ready", ld_ready, 0);
    checkOutput("t5_ar_we", imem_we, 0);
    checkOutput("t5_ar_waddr", imem_waddr, 0);
    checkOutput("t5_ar_busy", busy, 0);
    checkOutput("t5_ar_cpu_reset", cpu_reset, 1);
    #2 reset = 1'b0;
    tick();
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 32'hE000, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t5_reload_we", imem_we, 1);
    checkOutput("t5_reload_waddr", imem_waddr, 0);
    checkOutput("t5_reload_wdata", imem_wdata, 32'hE000);

    // Overflow on the 4-word instance: 5 words offered, no ld_last.
    start4 = 1;
    tick();
    start4 = 0;
    for (int i = 0; i < 5; i++) begin
      ld_valid4 = 1;
      ld_data4  = 32'hF00 + i;
      ld_last4  = 0;
      tick();
      if (i < 3) begin
        checkOutput("t6_waddr", imem_waddr4, i);
        checkOutput("t6_no_err", load_err4, 0);
      end else if (i == 3) begin
        checkOutput("t6_we3", imem_we4, 1);
        checkOutput("t6_waddr3", imem_waddr4, 3);
        checkOutput("t6_wdata3", imem_wdata4, 32'hF03);
        checkOutput("t6_load_err", load_err4, 1);
        checkOutput("t6_done", done4, 1);
        checkOutput("t6_ready", ld_ready4, 0);
      end else begin
        checkOutput("t6_no_5th_we", imem_we4, 0);
        checkOutput("t6_cpu_reset", cpu_reset4, 1);
        checkOutput("t6_cpu_run", cpu_run4, 0);
        checkOutput("t6_busy", busy4, 0);
      end
    end
    ld_valid4 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
